if_fetch_queue: RTL and testbench
=================================

# if_fetch_queue

Instruction fetch queue between the IF stage and the IF/ID boundary of the ARM pipeline. It buffers up to DEPTH fetched (PC, instruction) pairs so that IF can keep fetching while ID is frozen by a hazard. It also discards all buffered work in one cycle when a branch is taken. IF stops advancing whenever the queue is full.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- WIDTH, 32, width of the PC and instruction fields

Ports:
- clk  in  1  single clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  IF presents a fetched pair this cycle
- in_pc  in  WIDTH  PC+4 value produced by IF
- in_inst  in  WIDTH  instruction word produced by IF
- in_ready  out  1  queue accepts a push this cycle; IF freezes when low
- flush  in  1  branch taken; discard every buffered entry
- out_valid  out  1  head entry is valid
- out_pc  out  WIDTH  head entry PC
- out_inst  out  WIDTH  head entry instruction
- out_ready  in  1  ID consumes the head this cycle (low while ID is frozen)
- count  out  $clog2(DEPTH+1)  number of valid entries
- full  out  1  count == DEPTH
- empty  out  1  count == 0

## Operation
- Circular buffer with separate read and write pointers, each $clog2(DEPTH) bits, plus a count register.
- Pointers increment modulo DEPTH and wrap silently from DEPTH-1 to 0.
- Push condition: push = in_valid & in_ready & ~flush. Writes {in_pc, in_inst} at wr_ptr.
- Pop condition: pop = out_valid & out_ready & ~flush. Advances rd_ptr.
- in_ready = ~full. There is no pass-through when full: a push while full is refused even if a pop occurs in the same cycle.
- Simultaneous push and pop (queue neither empty nor full): both pointers advance and count is unchanged.
- Count update:
  - push only: +1
  - pop only: −1
  - both or neither: unchanged
- Output is first-word fall-through:
  - out_valid = ~empty.
  - out_pc and out_inst are combinational reads of entry rd_ptr while not empty.
  - While empty, out_pc and out_inst are driven to 0 (a bubble).
- Flush has priority over both push and pop. On the next edge, count becomes 0 and both pointers become 0. Data entries need not be cleared.
- A pair presented together with flush is dropped. IF re-fetches from the branch target.
- Reset behaves as flush, with precedence over everything else.
- Reset values:
  - count = 0, empty = 1, full = 0, in_ready = 1
  - out_valid = 0, out_pc = 0, out_inst = 0
- No error state exists. Overflow is impossible because in_ready gates the push. Underflow is impossible because out_valid gates the pop.

## Timing
- Push-to-output latency is 1 cycle. A pair pushed at edge N into an empty queue appears on out_* with out_valid = 1 in the cycle after edge N.
- full, empty, count and in_ready are registered-state derived. They reflect the current contents, with no combinational path from in_valid or out_ready.
- flush asserted in cycle N: out_valid = 0 and in_ready = 1 from cycle N+1. out_* are still visible during cycle N itself, and ID must ignore them under flush.
- rst asserted mid-operation behaves identically to flush on the next edge. It overrides a simultaneous push, pop or flush.
- Throughput is one push and one pop per cycle, sustained, when the queue is neither empty nor full.

## Test plan
- Reset then idle: rst = 1 for 2 cycles, release -> count = 0, empty = 1, in_ready = 1, out_valid = 0, out_inst = 0.
- Fill while ID frozen: out_ready = 0, push pc = 4, 8, 12, 16 with inst 0xE3A01001..0xE3A01004 -> count = 4, full = 1, in_ready = 0; a fifth push (pc = 20) is refused and the contents are unchanged.
- Drain in order: from full, out_ready = 1, in_valid = 0 -> out_pc is 4, 8, 12, 16 on four consecutive cycles, then empty = 1 and out_inst = 0.
- Steady streaming with wrap: push and pop every cycle for 10 cycles, starting with 2 entries -> count stays 2, the output order equals the input order, and the pointers wrap past 3 without loss.
- Flush with simultaneous push and pop: count = 3, then flush = 1, in_valid = 1, out_ready = 1 -> next cycle count = 0, out_valid = 0; a subsequent push of pc = 0x100 appears at the output one cycle later.
- Reset mid-stream: count = 2 with in_valid = 1, rst = 1 for one cycle -> count = 0, the pushed pair is not stored, out_valid = 0.

Source files
------------

// File: rtl/if_fetch_queue_if.sv
// if_fetch_queue_if: IF-side push, ID-side pop and status signals of the fetch queue
interface if_fetch_queue_if #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
);
  localparam int CW = $clog2(DEPTH + 1);
  logic          in_valid;
  logic [WIDTH-1:0] in_pc;
  logic [WIDTH-1:0] in_inst;
  logic          in_ready;
  logic          flush;
  logic          out_valid;
  logic [WIDTH-1:0] out_pc;
  logic [WIDTH-1:0] out_inst;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          full;
  logic          empty;
  modport master (
    output in_valid, in_pc, in_inst, flush, out_ready,
    input  in_ready, out_valid, out_pc, out_inst, count, full, empty
  );
  modport slave (
    input  in_valid, in_pc, in_inst, flush, out_ready,
    output in_ready, out_valid, out_pc, out_inst, count, full, empty
  );
endinterface

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: FWFT circular buffer of (PC, inst) pairs between IF and ID; clk/rst plus queue port q (slave)
module if_fetch_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst,
  if_fetch_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  logic [2*WIDTH-1:0] mem [DEPTH];
  logic [2*WIDTH-1:0] head;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  logic push, pop, full, empty;
  assign full = cnt == CW'(DEPTH);
  assign empty = cnt == '0;
  assign push = q.in_valid & ~full & ~q.flush;
  assign pop = ~empty & q.out_ready & ~q.flush;
  assign head = mem[rd_ptr];
  assign q.in_ready = ~full;
  assign q.out_valid = ~empty;
  assign q.out_pc = empty ? '0 : head[2*WIDTH-1:WIDTH];
  assign q.out_inst = empty ? '0 : head[WIDTH-1:0];
  assign q.count = cnt;
  assign q.full = full;
  assign q.empty = empty;
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk) begin
    if (push && !rst) mem[wr_ptr] <= {q.in_pc, q.in_inst};
  end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed self-checking bench for if_fetch_queue
module tb_if_fetch_queue;
  logic clk = 0;
  logic rst;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  if_fetch_queue_if #(.DEPTH(4), .WIDTH(32)) q ();
  if_fetch_queue #(.DEPTH(4), .WIDTH(32)) dut (.clk(clk), .rst(rst), .q(q.slave));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1;
    q.in_valid = 0; q.in_pc = 0; q.in_inst = 0; q.flush = 0; q.out_ready = 0;
    step(); step();
    rst = 0;
    chk("rst_count", 32'(q.count), 0);
    chk("rst_empty", 32'(q.empty), 1);
    chk("rst_full", 32'(q.full), 0);
    chk("rst_in_ready", 32'(q.in_ready), 1);
    chk("rst_out_valid", 32'(q.out_valid), 0);
    chk("rst_out_pc", q.out_pc, 0);
    chk("rst_out_inst", q.out_inst, 0);
    // fill while ID frozen
    for (int i = 1; i <= 4; i++) begin
      q.in_valid = 1; q.in_pc = 32'(4 * i); q.in_inst = 32'hE3A01000 + 32'(i);
      step();
      if (i == 1) begin
        chk("fill_first_valid", 32'(q.out_valid), 1);
        chk("fill_first_pc", q.out_pc, 4);
      end
    end
    chk("fill_count", 32'(q.count), 4);
    chk("fill_full", 32'(q.full), 1);
    chk("fill_in_ready", 32'(q.in_ready), 0);
    q.in_pc = 20; q.in_inst = 32'hE3A01005;
    step();
    q.in_valid = 0;
    chk("refuse_count", 32'(q.count), 4);
    chk("refuse_head_pc", q.out_pc, 4);
    // drain in order
    q.out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain_pc", q.out_pc, 32'(4 * i));
      chk("drain_inst", q.out_inst, 32'hE3A01000 + 32'(i));
      step();
    end
    chk("drain_empty", 32'(q.empty), 1);
    chk("drain_out_inst", q.out_inst, 0);
    chk("drain_out_pc", q.out_pc, 0);
    // preload 2 entries then stream push+pop for 10 cycles
    q.out_ready = 0; q.in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      q.in_pc = 32'h200 + 32'(4 * i); q.in_inst = 32'hA000 + 32'(i);
      step();
    end
    q.out_ready = 1;
    for (int k = 0; k < 10; k++) begin
      q.in_pc = 32'h208 + 32'(4 * k); q.in_inst = 32'hA002 + 32'(k);
      chk("stream_head_pc", q.out_pc, 32'h200 + 32'(4 * k));
      chk("stream_head_inst", q.out_inst, 32'hA000 + 32'(k));
      step();
      chk("stream_count", 32'(q.count), 2);
    end
    chk("stream_tail_pc", q.out_pc, 32'h228);
    // third entry, then flush with push and pop pending
    q.out_ready = 0; q.in_pc = 32'h230; q.in_inst = 32'hA00C;
    step();
    chk("preflush_count", 32'(q.count), 3);
    q.flush = 1; q.in_valid = 1; q.out_ready = 1; q.in_pc = 32'h300; q.in_inst = 32'hBBBB;
    step();
    q.flush = 0; q.out_ready = 0;
    chk("flush_count", 32'(q.count), 0);
    chk("flush_out_valid", 32'(q.out_valid), 0);
    chk("flush_in_ready", 32'(q.in_ready), 1);
    chk("flush_out_pc", q.out_pc, 0);
    q.in_pc = 32'h100; q.in_inst = 32'hC100;
    step();
    chk("postflush_valid", 32'(q.out_valid), 1);
    chk("postflush_pc", q.out_pc, 32'h100);
    chk("postflush_inst", q.out_inst, 32'hC100);
    chk("postflush_count", 32'(q.count), 1);
    // reset mid-stream
    q.in_pc = 32'h104; q.in_inst = 32'hC104;
    step();
    chk("prerst_count", 32'(q.count), 2);
    rst = 1; q.in_pc = 32'h108; q.in_inst = 32'hC108;
    step();
    rst = 0; q.in_valid = 0;
    chk("midrst_count", 32'(q.count), 0);
    chk("midrst_out_valid", 32'(q.out_valid), 0);
    chk("midrst_out_pc", q.out_pc, 0);
    q.in_valid = 1; q.in_pc = 32'h10C; q.in_inst = 32'hC10C;
    step();
    q.in_valid = 0;
    chk("postrst_pc", q.out_pc, 32'h10C);
    chk("postrst_count", 32'(q.count), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
